// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the instruction/data memory arbiter
package mem_arb_pkg;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

endpackage

// File: rtl/mem_arb_fifo.sv
// rtl/mem_arb_fifo.sv - in-order source-ID FIFO of outstanding memory transactions
module mem_arb_fifo
    import mem_arb_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  src_e             push_src_i,
    input  logic             pop_i,
    output src_e             head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    src_e             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Explicit wrap so depths that are not a power of two still cycle correctly.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign head_o  = r_mem[r_rd_ptr];
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_src_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin instr/data arbiter onto one req/gnt/rvalid memory port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int  MAX_OUTSTANDING = 2,
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        protocol_err_o
);

    logic             r_lock;
    src_e             r_lock_src;
    src_e             r_last_src;
    logic             r_err;
    logic             w_sel_valid;
    src_e             w_sel_src;
    logic             w_grant;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    src_e             w_head;
    logic [CNT_W-1:0] w_count;

    // A pending (ungranted) address phase keeps its source regardless of priority.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_src   = SRC_DATA;
        if (r_lock) begin
            w_sel_valid = 1'b1;
            w_sel_src   = r_lock_src;
        end else if (instr_req_i && data_req_i) begin
            w_sel_valid = 1'b1;
            if (r_last_src == SRC_DATA) begin
                w_sel_src = SRC_INSTR;
            end else begin
                w_sel_src = SRC_DATA;
            end
        end else if (instr_req_i) begin
            w_sel_valid = 1'b1;
            w_sel_src   = SRC_INSTR;
        end else if (data_req_i) begin
            w_sel_valid = 1'b1;
            w_sel_src   = SRC_DATA;
        end
    end

    assign mem_req_o   = w_sel_valid & ~w_full & ~rst_i;
    assign w_grant     = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = w_grant & (w_sel_src == SRC_INSTR);
    assign data_gnt_o  = w_grant & (w_sel_src == SRC_DATA);

    always_comb begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
        if (w_sel_valid && (w_sel_src == SRC_INSTR)) begin
            mem_we_o    = 1'b0;
            mem_be_o    = 4'hF;
            mem_addr_o  = instr_addr_i;
            mem_wdata_o = 32'h0;
        end
    end

    assign w_pop          = mem_rvalid_i & ~w_empty & ~rst_i;
    assign instr_rvalid_o = w_pop & (w_head == SRC_INSTR);
    assign data_rvalid_o  = w_pop & (w_head == SRC_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign protocol_err_o = r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lock     <= 1'b0;
            r_lock_src <= SRC_INSTR;
            r_last_src <= SRC_DATA;
            r_err      <= 1'b0;
        end else begin
            if (w_grant) begin
                r_lock     <= 1'b0;
                r_last_src <= w_sel_src;
            end else if (mem_req_o) begin
                r_lock     <= 1'b1;
                r_lock_src <= w_sel_src;
            end
            if (mem_rvalid_i && (w_count == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    mem_arb_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (w_grant),
        .push_src_i (w_sel_src),
        .pop_i      (w_pop),
        .head_o     (w_head),
        .full_o     (w_full),
        .empty_o    (w_empty),
        .count_o    (w_count)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and scoreboarded bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        protocol_err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .protocol_err_o(protocol_err_o)
    );

    task automatic idle();
        instr_req_i = 0; instr_addr_i = 0;
        data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); idle(); rst_i = 1;
        @(negedge clk); rst_i = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_i = 1; instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
        #1;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_req_o); end
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", {instr_gnt_o, data_gnt_o}); end
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b exp 00", {instr_rvalid_o, data_rvalid_o}); end
        checks++; if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", protocol_err_o); end
        @(posedge clk); @(negedge clk); idle(); rst_i = 0;
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            instr_req_i = (k < 4); data_req_i = (k < 4);
            instr_addr_i = 32'h10; data_addr_i = 32'h20;
            mem_gnt_i = 1; mem_rvalid_i = (k > 0); mem_rdata_i = 32'hA000_0000 + k;
            #1;
            if (k < 4) begin
                exp_addr = (k % 2 == 0) ? 32'h10 : 32'h20;
                checks++; if ({instr_gnt_o, data_gnt_o} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL rr_gnt k=%0d got %b", k, {instr_gnt_o, data_gnt_o}); end
                checks++; if (mem_addr_o !== exp_addr) begin
                    errors++; $display("FAIL rr_addr k=%0d got %h exp %h", k, mem_addr_o, exp_addr); end
            end
            if (k > 0) begin
                checks++; if ({instr_rvalid_o, data_rvalid_o} !== (((k - 1) % 2 == 0) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL rr_rvalid k=%0d got %b", k, {instr_rvalid_o, data_rvalid_o}); end
                checks++; if (instr_rdata_o !== mem_rdata_i || data_rdata_o !== mem_rdata_i) begin
                    errors++; $display("FAIL rr_rdata k=%0d got %h/%h exp %h", k, instr_rdata_o, data_rdata_o, mem_rdata_i); end
            end
        end
        @(negedge clk); idle();
    endtask

    task automatic test_lock();
        instr_req_i = 1; instr_addr_i = 32'h40; mem_gnt_i = 1;
        #1;
        checks++; if (instr_gnt_o !== 1'b1) begin errors++; $display("FAIL lock_prime_gnt got %b exp 1", instr_gnt_o); end
        @(negedge clk); instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; #1;
        checks++; if (instr_rvalid_o !== 1'b1) begin errors++; $display("FAIL lock_prime_rvalid got %b exp 1", instr_rvalid_o); end
        @(negedge clk);
        mem_rvalid_i = 0; instr_req_i = 1; instr_addr_i = 32'h100;
        data_addr_i = 32'h2000; data_we_i = 1; data_be_i = 4'b0011; data_wdata_i = 32'hDEADBEEF;
        #1;
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin
            errors++; $display("FAIL lock_c1 got req %b addr %h exp 1 00000100", mem_req_o, mem_addr_o); end
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk); data_req_i = 1; #1;
            checks++; if (mem_addr_o !== 32'h100 || mem_be_o !== 4'hF || mem_we_o !== 1'b0 || mem_wdata_o !== 32'h0) begin
                errors++; $display("FAIL lock_hold c%0d got addr %h be %h we %b wdata %h", c, mem_addr_o, mem_be_o, mem_we_o, mem_wdata_o); end
            checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b00) begin
                errors++; $display("FAIL lock_nognt c%0d got %b exp 00", c, {instr_gnt_o, data_gnt_o}); end
        end
        @(negedge clk); mem_gnt_i = 1; #1;
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin errors++; $display("FAIL lock_c4_gnt got %b exp 10", {instr_gnt_o, data_gnt_o}); end
        @(negedge clk); instr_req_i = 0; #1;
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b01 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h2000) begin
            errors++; $display("FAIL lock_c5_data got gnt %b we %b addr %h", {instr_gnt_o, data_gnt_o}, mem_we_o, mem_addr_o); end
        @(negedge clk); data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; #1;
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin errors++; $display("FAIL lock_rv1 got %b exp 10", {instr_rvalid_o, data_rvalid_o}); end
        @(negedge clk); #1;
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin errors++; $display("FAIL lock_rv2 got %b exp 01", {instr_rvalid_o, data_rvalid_o}); end
        @(negedge clk); idle();
    endtask

    task automatic test_full();
        instr_req_i = 1; instr_addr_i = 32'h300; mem_gnt_i = 1; #1;
        checks++; if (instr_gnt_o !== 1'b1) begin errors++; $display("FAIL full_g1 got %b exp 1", instr_gnt_o); end
        @(negedge clk); #1;
        checks++; if (instr_gnt_o !== 1'b1) begin errors++; $display("FAIL full_g2 got %b exp 1", instr_gnt_o); end
        @(negedge clk); #1;
        checks++; if (mem_req_o !== 1'b0 || instr_gnt_o !== 1'b0) begin
            errors++; $display("FAIL full_block got req %b gnt %b exp 0 0", mem_req_o, instr_gnt_o); end
        @(negedge clk); mem_rvalid_i = 1; #1;
        checks++; if (mem_req_o !== 1'b0 || instr_gnt_o !== 1'b0 || instr_rvalid_o !== 1'b1) begin
            errors++; $display("FAIL full_nobypass got req %b gnt %b rv %b exp 0 0 1", mem_req_o, instr_gnt_o, instr_rvalid_o); end
        @(negedge clk); mem_rvalid_i = 0; #1;
        checks++; if (mem_req_o !== 1'b1 || instr_gnt_o !== 1'b1) begin
            errors++; $display("FAIL full_regrant got req %b gnt %b exp 1 1", mem_req_o, instr_gnt_o); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); instr_req_i = 0; mem_rvalid_i = 1; #1;
            checks++; if (instr_rvalid_o !== 1'b1) begin errors++; $display("FAIL full_drain%0d got %b exp 1", c, instr_rvalid_o); end
        end
        @(negedge clk); idle();
    endtask

    task automatic test_write();
        data_req_i = 1; data_we_i = 1; data_be_i = 4'b0011; data_wdata_i = 32'hDEADBEEF;
        data_addr_i = 32'h2000; instr_addr_i = 32'h500; mem_gnt_i = 1; #1;
        checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_be_o !== 4'b0011 ||
                      mem_wdata_o !== 32'hDEADBEEF || mem_addr_o !== 32'h2000) begin
            errors++; $display("FAIL write_fields got req %b we %b be %h wdata %h addr %h", mem_req_o, mem_we_o, mem_be_o, mem_wdata_o, mem_addr_o); end
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b01) begin errors++; $display("FAIL write_gnt got %b exp 01", {instr_gnt_o, data_gnt_o}); end
        @(negedge clk); data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h12345678; #1;
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b01 || data_rdata_o !== 32'h12345678) begin
            errors++; $display("FAIL write_resp got rv %b rdata %h exp 01 12345678", {instr_rvalid_o, data_rvalid_o}, data_rdata_o); end
        @(negedge clk); idle();
    endtask

    task automatic test_push_pop();
        instr_req_i = 1; mem_gnt_i = 1; #1;
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin errors++; $display("FAIL pp_a got %b exp 10", {instr_gnt_o, data_gnt_o}); end
        @(negedge clk); instr_req_i = 0; data_req_i = 1; mem_rvalid_i = 1; #1;
        checks++; if ({instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o} !== 4'b0110) begin
            errors++; $display("FAIL pp_same_cycle got %b exp 0110", {instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o}); end
        @(negedge clk); data_req_i = 0; instr_req_i = 1; mem_rvalid_i = 0; #1;
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin errors++; $display("FAIL pp_c got %b exp 10", {instr_gnt_o, data_gnt_o}); end
        @(negedge clk); #1;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL pp_count_full got req %b exp 0", mem_req_o); end
        @(negedge clk); instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; #1;
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin errors++; $display("FAIL pp_rv_b got %b exp 01", {instr_rvalid_o, data_rvalid_o}); end
        @(negedge clk); #1;
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin errors++; $display("FAIL pp_rv_c got %b exp 10", {instr_rvalid_o, data_rvalid_o}); end
        @(negedge clk); idle();
    endtask

    task automatic test_random();
        bit q[$];
        bit i_pend = 0, d_pend = 0, m_last = 1, m_lock = 0, m_lock_src = 0, e_src, e_req;
        int grants = 0, cyc = 0;
        pulse_reset();
        while (grants < 20 && cyc < 400) begin
            @(negedge clk);
            if (!i_pend && $urandom_range(0, 1) == 1) begin i_pend = 1; instr_addr_i = $urandom; end
            if (!d_pend && $urandom_range(0, 1) == 1) begin
                d_pend = 1; data_addr_i = $urandom; data_we_i = 1'($urandom); data_be_i = 4'($urandom);
                data_wdata_i = $urandom;
            end
            instr_req_i = i_pend; data_req_i = d_pend;
            mem_gnt_i = ($urandom_range(0, 2) != 0);
            mem_rvalid_i = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_rdata_i = $urandom;
            #1;
            e_req = (i_pend || d_pend) && (q.size() < 2);
            if (m_lock) e_src = m_lock_src;
            else if (i_pend && d_pend) e_src = !m_last;
            else e_src = !i_pend;
            checks++; if (mem_req_o !== e_req) begin errors++; $display("FAIL rnd_req cyc %0d got %b exp %b", cyc, mem_req_o, e_req); end
            checks++; if ({instr_gnt_o, data_gnt_o} !== {e_req && mem_gnt_i && !e_src, e_req && mem_gnt_i && e_src}) begin
                errors++; $display("FAIL rnd_gnt cyc %0d got %b src %b", cyc, {instr_gnt_o, data_gnt_o}, e_src); end
            if (e_req) begin
                checks++; if (mem_addr_o !== (e_src ? data_addr_i : instr_addr_i)) begin
                    errors++; $display("FAIL rnd_addr cyc %0d got %h", cyc, mem_addr_o); end
            end
            checks++; if ({instr_rvalid_o, data_rvalid_o} !== (mem_rvalid_i ? (q[0] ? 2'b01 : 2'b10) : 2'b00)) begin
                errors++; $display("FAIL rnd_rvalid cyc %0d got %b", cyc, {instr_rvalid_o, data_rvalid_o}); end
            if (mem_rvalid_i) void'(q.pop_front());
            if (e_req && mem_gnt_i) begin
                q.push_back(e_src); m_last = e_src; m_lock = 0; grants++;
                if (e_src) d_pend = 0; else i_pend = 0;
            end else if (e_req) begin
                m_lock = 1; m_lock_src = e_src;
            end
            cyc++;
        end
        checks++; if (grants < 20) begin errors++; $display("FAIL rnd_timeout got %0d grants exp 20", grants); end
        for (int c = 0; c < 4 && q.size() > 0; c++) begin
            @(negedge clk); mem_gnt_i = 0; mem_rvalid_i = 1; #1;
            checks++; if ({instr_rvalid_o, data_rvalid_o} !== (q[0] ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL rnd_drain got %b head %b", {instr_rvalid_o, data_rvalid_o}, q[0]); end
            void'(q.pop_front());
        end
        pulse_reset();
    endtask

    task automatic test_protocol_err();
        @(negedge clk); idle(); mem_rvalid_i = 1; #1;
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin errors++; $display("FAIL perr_rv got %b exp 00", {instr_rvalid_o, data_rvalid_o}); end
        @(negedge clk); mem_rvalid_i = 0; #1;
        checks++; if (protocol_err_o !== 1'b1) begin errors++; $display("FAIL perr_set got %b exp 1", protocol_err_o); end
        @(negedge clk); @(negedge clk); #1;
        checks++; if (protocol_err_o !== 1'b1) begin errors++; $display("FAIL perr_sticky got %b exp 1", protocol_err_o); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1;
        @(negedge clk);
        @(negedge clk); mem_rvalid_i = 1; rst_i = 1; #1;
        checks++; if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, protocol_err_o} !== 6'b0) begin
            errors++; $display("FAIL rstmid_outs got %b exp 000000", {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, protocol_err_o}); end
        @(negedge clk); idle(); rst_i = 0;
        @(negedge clk); mem_rvalid_i = 1; #1;
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin errors++; $display("FAIL rstmid_stray got %b exp 00", {instr_rvalid_o, data_rvalid_o}); end
        @(negedge clk); mem_rvalid_i = 0; #1;
        checks++; if (protocol_err_o !== 1'b1) begin errors++; $display("FAIL rstmid_err got %b exp 1", protocol_err_o); end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_round_robin();
        test_lock();
        test_full();
        test_write();
        test_push_pop();
        test_random();
        test_protocol_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
